// File: rtl/imem_arbiter.sv
// Purpose: shares a single-port, 1-cycle-latency instruction memory between fetch (port 0) and debug loader (port 1).
// Latency: a response is valid exactly one cycle after its request is accepted; one read per cycle when consumed promptly.
// Backpressure: a stalled response is captured in a hold register and blocks all new grants until it is consumed.
module imem_arbiter #(
  parameter int addrWidth  = 32,
  parameter int instrWidth = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [addrWidth-1:0]  req0_addr,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [instrWidth-1:0] resp0_instr,
  output logic                  resp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [addrWidth-1:0]  req1_addr,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [instrWidth-1:0] resp1_instr,
  output logic                  resp1_err,
  output logic [addrWidth-1:0]  mem_addr,
  input  logic [instrWidth-1:0] mem_instr
);

  // IDLE: nothing outstanding; FLIGHT: word on mem_instr now; HOLD: word parked in r_hold
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rr_ptr;
  logic                  r_owner;
  logic                  r_err;
  logic [addrWidth-1:0]  r_last_addr;
  logic [instrWidth-1:0] r_hold;

  logic                  w_owner_rdy;
  logic                  w_can_issue;
  logic                  w_grant_vld;
  logic                  w_grant_id;
  logic [addrWidth-1:0]  w_grant_addr;
  logic                  w_capture;
  logic                  w_resp_vld;
  logic [instrWidth-1:0] w_resp_dat;

  assign w_owner_rdy  = r_owner ? resp1_ready : resp0_ready;
  assign w_grant_addr = w_grant_id ? req1_addr : req0_addr;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue permission, round-robin grant and next-state selection
  always_comb begin
    w_can_issue = 1'b0;
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    w_capture   = 1'b0;
    w_state_nxt = r_state;

    case (r_state)
      IDLE:    w_can_issue = 1'b1;
      FLIGHT,
      HOLD:    w_can_issue = w_owner_rdy;
      default: w_can_issue = 1'b0;
    endcase

    // Grants are suppressed while reset is held so nothing is accepted and then dropped
    if (reset && w_can_issue) begin
      if (req0_valid && req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = r_rr_ptr;
      end else if (req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end else if (req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = FLIGHT;
        end
      end
      FLIGHT: begin
        if (w_owner_rdy) begin
          w_state_nxt = w_grant_vld ? FLIGHT : IDLE;
        end else begin
          // The memory only drives the word for this one cycle, so park it
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end
      end
      HOLD: begin
        if (w_owner_rdy) begin
          w_state_nxt = w_grant_vld ? FLIGHT : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ownership, error flag, round-robin pointer, last address and hold register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_last_addr <= '0;
      r_hold      <= '0;
    end else begin
      if (w_grant_vld) begin
        r_rr_ptr    <= ~w_grant_id;
        r_owner     <= w_grant_id;
        r_err       <= |w_grant_addr[1:0];
        r_last_addr <= w_grant_addr;
      end
      if (w_capture) begin
        r_hold <= mem_instr;
      end
    end
  end

  // Response routing: only the owning port ever sees valid, data or err
  always_comb begin
    w_resp_vld  = reset && (r_state != IDLE);
    w_resp_dat  = (r_state == HOLD) ? r_hold : mem_instr;
    resp0_valid = w_resp_vld && !r_owner;
    resp1_valid = w_resp_vld && r_owner;
    resp0_instr = resp0_valid ? w_resp_dat : '0;
    resp1_instr = resp1_valid ? w_resp_dat : '0;
    resp0_err   = resp0_valid && r_err;
    resp1_err   = resp1_valid && r_err;
    req0_ready  = w_grant_vld && !w_grant_id;
    req1_ready  = w_grant_vld && w_grant_id;
    // Idle cycles repeat the last address so the memory input does not toggle needlessly
    mem_addr    = w_grant_vld ? w_grant_addr : r_last_addr;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port, 1-cycle-latency instruction memory between two requesters: port 0 is the core fetch unit and port 1 is the debug/program loader.
- Arbitrates per request with round-robin priority and sequences each memory read.
- Routes the returned word to the owning requester with valid/ready handshakes.
- Holds a response when its requester stalls, and sustains one read per cycle when responses are consumed promptly.

Parameters:
- addrWidth, 32, width of request and memory addresses
- instrWidth, 32, width of an instruction word

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  active-low synchronous reset, sampled on posedge clock
- req0_valid  input  1  port 0 read request
- req0_ready  output  1  port 0 request accepted this cycle
- req0_addr  input  addrWidth  port 0 byte address
- resp0_valid  output  1  port 0 response available
- resp0_ready  input  1  port 0 consumes response
- resp0_instr  output  instrWidth  port 0 returned word
- resp0_err  output  1  port 0 request was misaligned
- req1_valid, req1_ready, req1_addr, resp1_valid, resp1_ready, resp1_instr, resp1_err  same as port 0, for port 1
- mem_addr  output  addrWidth  address to instruction memory; sampled by memory at posedge
- mem_instr  input  instrWidth  memory read data; valid during the cycle after the edge that sampled mem_addr

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, rr_ptr=0, last_addr=0.
  - All ready/valid/err outputs 0, resp*_instr 0.
  - Any in-flight or held response is discarded.
- Memory timing: an address driven on mem_addr during cycle k returns its word on mem_instr in cycle k+1 only. The memory has no valid signal; the arbiter tracks ownership itself.
- States:
  - IDLE: nothing outstanding.
  - FLIGHT: word returning this cycle; owner id recorded.
  - HOLD: word captured in hold register and not yet consumed.
- can_issue:
  - IDLE: 1.
  - FLIGHT: 1 iff the owner's resp_ready==1.
  - HOLD: 1 iff the owner's resp_ready==1.
- Grant, combinational:
  - Only if can_issue.
  - If exactly one req_valid, that port wins.
  - If both, the port equal to rr_ptr wins.
  - reqN_ready = grant to N.
  - A request is accepted when valid and ready are both 1 in the same cycle.
- mem_addr:
  - Equals the granted port's addr when a grant occurs.
  - Otherwise equals last_addr.
  - last_addr updates to the issued address on every grant.
- On accept:
  - rr_ptr <= the other port's id.
  - Record owner and err = (addr[1:0]!=0).
  - Next state FLIGHT.
- Misaligned requests still read the memory. The word is returned unmodified with resp_err=1.
- FLIGHT:
  - Owner's resp_valid=1, resp_instr=mem_instr (combinational pass-through), resp_err=recorded err.
  - If owner's resp_ready==1: consumed. Next state is FLIGHT if a new grant occurs this cycle, else IDLE.
  - If owner's resp_ready==0: capture mem_instr into the hold register, go to HOLD, no grant.
- HOLD:
  - Owner's resp_valid=1, resp_instr=hold register.
  - On resp_ready==1: consumed. Next state FLIGHT if a grant occurs this cycle, else IDLE.
  - resp_valid remains asserted and data stable until consumed.
- Non-owner port: resp_valid=0, resp_instr=0, resp_err=0.
- Throughput and latency:
  - Back-to-back accepts every cycle while responses are consumed the cycle they appear.
  - Latency from accept to resp_valid is exactly 1 cycle.
- At most one response outstanding. There is never simultaneous resp_valid on both ports.
- req ready/valid rule: a requester must hold valid and addr stable until ready. The arbiter may deassert ready while valid is held.
- Reset mid-FLIGHT or mid-HOLD: resp_valid is 0 from the cycle after the reset edge. The dropped word is never delivered.

Test Plan:
- Single read: port 0 requests addr 0x100, memory word 0xDEADBEEF, resp0_ready=1 -> req0_ready=1 in cycle 0; resp0_valid=1, resp0_instr=0xDEADBEEF, resp0_err=0 in cycle 1; idle in cycle 2.
- Streaming: port 0 requests 0x0,0x4,0x8,0xC on consecutive cycles, resp0_ready held 1 -> 4 accepts in 4 cycles; responses in cycles 1-4 in order, matching the memory model.
- Contention: both valid continuously (port 0 at 0x10, port 1 at 0x20) after reset -> grants alternate 0,1,0,1; each response appears on the correct port only.
- Backpressure: port 1 reads 0x40 (word 0x12345678), resp1_ready=0 for 3 cycles while port 0 is valid -> resp1 held at 0x12345678 with resp1_valid=1; req0_ready=0 throughout; in the cycle resp1_ready=1, port 0 is granted.
- Misaligned: port 0 requests 0x102 -> word from memory model at 0x102 returned with resp0_err=1 one cycle later; next aligned request has resp0_err=0.
- Reset mid-operation: reset=0 during HOLD -> next cycle all resp*_valid=0, req*_ready=0; after release, rr_ptr=0, so simultaneous requests grant port 0 first.
